// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the MEM pipeline stage.
//   mem_state_e : MEM-stage FSM states (IDLE, WAIT)
//   DATA_W      : data/address width, REGN_W : register-number width
//   TIMEOUT_CYC_DEF : default WAIT-cycle limit for the optional timeout
//   mw_bus_t    : one MEM/WB register entry
package pipe_pkg;

  localparam int DATA_W          = 32;
  localparam int REGN_W          = 5;
  localparam int TIMEOUT_CYC_DEF = 15;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REGN_W-1:0] regn_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic  wreg;
    logic  m2reg;
    word_t mo;
    word_t alu;
    regn_t rn;
  } mw_bus_t;

endpackage

// File: rtl/pipe_mem_stage_if.sv
// pipe_mem_stage_if: data-memory request/response bus.
//   dmem_req, dmem_we, dmem_addr, dmem_wdata : request, driven by the MEM stage
//   dmem_ack, dmem_rdata                     : completion and load data, driven by memory
// Modports: master (MEM stage), slave (memory).
interface pipe_mem_stage_if;
  import pipe_pkg::*;

  logic  dmem_req;
  logic  dmem_we;
  word_t dmem_addr;
  word_t dmem_wdata;
  logic  dmem_ack;
  word_t dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/pipemwreg.sv
// pipemwreg: MEM/WB pipeline register.
//   clk, clrn : clock, asynchronous active-low reset
//   load_i    : 1 = capture d_i, 0 = insert a bubble (write-enables cleared)
//   d_i       : next MEM/WB entry
//   q_o       : current MEM/WB entry
module pipemwreg
  import pipe_pkg::*;
(
  input  logic    clk,
  input  logic    clrn,
  input  logic    load_i,
  input  mw_bus_t d_i,
  output mw_bus_t q_o
);

  mw_bus_t mw_q;
  mw_bus_t mw_d;

  // A bubble only has to kill the register write and load-select; the
  // data fields are don't-care downstream, so they simply hold.
  always_comb begin
    mw_d = mw_q;
    if (load_i) begin
      mw_d = d_i;
    end else begin
      mw_d.wreg  = 1'b0;
      mw_d.m2reg = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) mw_q <= '0;
    else       mw_q <= mw_d;
  end

  assign q_o = mw_q;

endmodule

// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: MEM stage of the pipeline with a stalling data-memory port.
//   clk, clrn                  : clock, asynchronous active-low reset
//   mwreg, mm2reg, mwmem       : EX/MEM control (register write, load, store)
//   malu, mb, mrn              : address/ALU result, store data, destination reg
//   dmem                       : data-memory bus (master side)
//   stall                      : combinational; holds EX/MEM and earlier stages
//   wwreg, wm2reg, wmo, walu, wrn : MEM/WB register outputs
//   mem_err                    : one-cycle timeout pulse
// Optional feature: define PIPE_MEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYC WAIT cycles without dmem_ack; otherwise WAIT lasts until ack.
//
// state | meaning
// IDLE  | no access outstanding; memops launch a request from here
// WAIT  | request outstanding, waiting for dmem_ack (or timeout)
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      clrn,
  input  logic                      mwreg,
  input  logic                      mm2reg,
  input  logic                      mwmem,
  input  word_t                     malu,
  input  word_t                     mb,
  input  regn_t                     mrn,
  pipe_mem_stage_if.master          dmem,
  output logic                      stall,
  output logic                      wwreg,
  output logic                      wm2reg,
  output word_t                     wmo,
  output word_t                     walu,
  output regn_t                     wrn,
  output logic                      mem_err
);

  mem_state_e state_q;
  logic       req_q;
  logic       we_q;
  word_t      addr_q;
  word_t      wdata_q;

  logic       memop;
  logic       tmo_hit;
  logic       mw_load;
  mw_bus_t    mw_d;
  mw_bus_t    mw_q;

  assign memop = mm2reg | mwmem;

`ifdef PIPE_MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Counter is zero on the first WAIT cycle, so the abort lands on the
  // TIMEOUT_CYC-th WAIT cycle. Wrap on the abort cycle is harmless: IDLE clears it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                  cnt_q <= '0;
    else if (state_q == ST_WAIT) cnt_q <= cnt_q + 1'b1;
    else                        cnt_q <= '0;
  end

  assign tmo_hit = (state_q == ST_WAIT) && !dmem.dmem_ack &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign mem_err = tmo_hit;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Stall and MEM/WB selection. While stalled the EX/MEM inputs are held,
  // so on completion they still describe the instruction being retired.
  always_comb begin
    stall       = 1'b0;
    mw_load     = 1'b0;
    mw_d.wreg   = mwreg;
    mw_d.m2reg  = mm2reg;
    mw_d.mo     = '0;
    mw_d.alu    = malu;
    mw_d.rn     = mrn;
    if (state_q == ST_IDLE) begin
      if (memop) stall   = 1'b1;
      else       mw_load = 1'b1;
    end else begin
      if (dmem.dmem_ack) begin
        mw_load = 1'b1;
        // Load+store together counts as a store: no load data returned.
        mw_d.mo = mwmem ? '0 : dmem.dmem_rdata;
      end else if (tmo_hit) begin
        mw_load   = 1'b1;
        mw_d.wreg = 1'b0;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (memop) begin
        state_q <= ST_WAIT;
        req_q   <= 1'b1;
        we_q    <= mwmem;
        addr_q  <= malu;
        wdata_q <= mb;
      end
    end else begin
      if (dmem.dmem_ack || tmo_hit) begin
        state_q <= ST_IDLE;
        req_q   <= 1'b0;
      end
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  pipemwreg u_mwreg (
    .clk    (clk),
    .clrn   (clrn),
    .load_i (mw_load),
    .d_i    (mw_d),
    .q_o    (mw_q)
  );

  assign wwreg  = mw_q.wreg;
  assign wm2reg = mw_q.m2reg;
  assign wmo    = mw_q.mo;
  assign walu   = mw_q.alu;
  assign wrn    = mw_q.rn;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb_pipe_mem_stage: self-checking bench for pipe_mem_stage.
// A memory responder acks each request on a programmed WAIT cycle and logs
// completed accesses; expected MEM/WB entries are queued at issue and popped
// when the instruction retires. Timeout checks run when PIPE_MEM_TIMEOUT_EN is set.
module tb_pipe_mem_stage;
  import pipe_pkg::*;

  typedef struct packed {
    logic  we;
    word_t addr;
    word_t wdata;
  } acc_t;

  logic  clk = 1'b0;
  logic  clrn;
  logic  mwreg, mm2reg, mwmem;
  word_t malu, mb;
  regn_t mrn;
  logic  stall, wwreg, wm2reg, mem_err;
  word_t wmo, walu;
  regn_t wrn;

  int checks = 0;
  int errors = 0;

  mw_bus_t exp_q[$];
  acc_t    acc_q[$];

  int    ack_k    = 1;
  logic  idle_ack = 1'b0;
  word_t rd_val   = '0;
  int    wait_n   = 0;
  acc_t  first_acc;
  logic  unstable = 1'b0;

  pipe_mem_stage_if dif ();

  pipe_mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .mwreg   (mwreg),
    .mm2reg  (mm2reg),
    .mwmem   (mwmem),
    .malu    (malu),
    .mb      (mb),
    .mrn     (mrn),
    .dmem    (dif),
    .stall   (stall),
    .wwreg   (wwreg),
    .wm2reg  (wm2reg),
    .wmo     (wmo),
    .walu    (walu),
    .wrn     (wrn),
    .mem_err (mem_err)
  );

  always #5 clk = ~clk;

  // Memory responder: updates 2 time units after each rising edge.
  initial begin
    dif.dmem_ack   = 1'b0;
    dif.dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (dif.dmem_req) begin
        wait_n++;
        if (wait_n == 1) first_acc = {dif.dmem_we, dif.dmem_addr, dif.dmem_wdata};
        else if ({dif.dmem_we, dif.dmem_addr, dif.dmem_wdata} != first_acc) unstable = 1'b1;
      end else begin
        wait_n = 0;
      end
      if (dif.dmem_req && ack_k != 0 && wait_n == ack_k) begin
        dif.dmem_ack   = 1'b1;
        dif.dmem_rdata = rd_val;
        acc_q.push_back({dif.dmem_we, dif.dmem_addr, dif.dmem_wdata});
      end else begin
        dif.dmem_ack   = idle_ack;
        dif.dmem_rdata = 32'hBAD0_0000 ^ word_t'(wait_n);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_nop();
    mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
    malu = '0; mb = '0; mrn = '0;
  endtask

  // Drives one instruction (called at edge+1) and waits until it retires.
  // Returns at edge+1 of the cycle where its MEM/WB entry is visible.
  task automatic issue(input logic w, input logic m2r, input logic wm,
                       input word_t alu, input word_t b, input regn_t rn,
                       input int k, input word_t rd,
                       output int n_stall, output logic err_seen,
                       output logic timed_out, output logic bub_bad);
    ack_k = k; rd_val = rd;
    mwreg = w; mm2reg = m2r; mwmem = wm; malu = alu; mb = b; mrn = rn;
    n_stall = 0; err_seen = 1'b0; timed_out = 1'b1; bub_bad = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #2;
      err_seen |= mem_err;
      if (c > 0 && (wwreg || wm2reg)) bub_bad = 1'b1;
      if (!stall) begin
        timed_out = 1'b0;
        break;
      end
      n_stall++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    drive_nop();
    #3;
    checks++;
    if ({dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata} !== 66'd0) begin
      errors++;
      $display("FAIL reset_req: got req=%b we=%b addr=%h wdata=%h exp all 0",
               dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata);
    end
    checks++;
    if ({wwreg, wm2reg, wmo, walu, wrn} !== 71'd0) begin
      errors++;
      $display("FAIL reset_mw: got %b %b %h %h %h exp all 0", wwreg, wm2reg, wmo, walu, wrn);
    end
    checks++;
    if ({stall, mem_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stall_err: got stall=%b mem_err=%b exp 0 0", stall, mem_err);
    end
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nonmemop();
    int n; logic e, t, bb; mw_bus_t got, ex;
    exp_q.push_back('{wreg: 1'b1, m2reg: 1'b0, mo: '0, alu: 32'h0000_1234, rn: 5'd5});
    issue(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h9999_9999, 5'd5, 1, '0, n, e, t, bb);
    got = {wwreg, wm2reg, wmo, walu, wrn}; ex = exp_q.pop_front();
    checks++;
    if (n !== 0 || t) begin
      errors++; $display("FAIL nonmemop1_stall: got %0d stall cycles exp 0", n);
    end
    checks++;
    if (got !== ex) begin
      errors++; $display("FAIL nonmemop1_mw: got %h exp %h", got, ex);
    end
    exp_q.push_back('{wreg: 1'b0, m2reg: 1'b0, mo: '0, alu: 32'hFFFF_FFFF, rn: 5'd31});
    issue(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd31, 1, '0, n, e, t, bb);
    got = {wwreg, wm2reg, wmo, walu, wrn}; ex = exp_q.pop_front();
    checks++;
    if (got !== ex || n !== 0 || dif.dmem_req !== 1'b0) begin
      errors++; $display("FAIL nonmemop2: got %h stall=%0d req=%b exp %h 0 0", got, n, dif.dmem_req, ex);
    end
    drive_nop();
  endtask

  task automatic test_load();
    int n; logic e, t, bb; mw_bus_t got, ex; acc_t a;
    acc_q.delete(); unstable = 1'b0;
    exp_q.push_back('{wreg: 1'b1, m2reg: 1'b1, mo: 32'hDEAD_BEEF, alu: 32'h100, rn: 5'd7});
    issue(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF, n, e, t, bb);
    got = {wwreg, wm2reg, wmo, walu, wrn}; ex = exp_q.pop_front();
    checks++;
    if (n !== 3 || t) begin
      errors++; $display("FAIL load_stall: got %0d stall cycles exp 3", n);
    end
    checks++;
    if (got !== ex) begin
      errors++; $display("FAIL load_mw: got %h exp %h", got, ex);
    end
    checks++;
    if (bb !== 1'b0) begin
      errors++; $display("FAIL load_bubble: got write-enable during stall exp bubble");
    end
    checks++;
    a = (acc_q.size() > 0) ? acc_q.pop_front() : '1;
    if (a !== {1'b0, 32'h100, 32'h0} || acc_q.size() != 0 || unstable !== 1'b0) begin
      errors++; $display("FAIL load_access: got we=%b addr=%h wdata=%h unstable=%b exp 0 100 0 0",
                         a.we, a.addr, a.wdata, unstable);
    end
    checks++;
    if (dif.dmem_req !== 1'b0) begin
      errors++; $display("FAIL load_req_drop: got req=%b exp 0", dif.dmem_req);
    end
    drive_nop();
  endtask

  task automatic test_store();
    int n; logic e, t, bb; mw_bus_t got, ex; acc_t a;
    acc_q.delete(); unstable = 1'b0;
    exp_q.push_back('{wreg: 1'b0, m2reg: 1'b0, mo: '0, alu: 32'h200, rn: 5'd9});
    issue(1'b0, 1'b0, 1'b1, 32'h200, 32'h55, 5'd9, 1, 32'h1111_2222, n, e, t, bb);
    got = {wwreg, wm2reg, wmo, walu, wrn}; ex = exp_q.pop_front();
    checks++;
    if (n !== 1 || t || got !== ex) begin
      errors++; $display("FAIL store_mw: got %h stall=%0d exp %h stall=1", got, n, ex);
    end
    checks++;
    a = (acc_q.size() > 0) ? acc_q.pop_front() : '0;
    if (a !== {1'b1, 32'h200, 32'h55}) begin
      errors++; $display("FAIL store_access: got we=%b addr=%h wdata=%h exp 1 200 55", a.we, a.addr, a.wdata);
    end
    drive_nop();
  endtask

  task automatic test_load_and_store();
    int n; logic e, t, bb; mw_bus_t got, ex; acc_t a;
    acc_q.delete(); unstable = 1'b0;
    exp_q.push_back('{wreg: 1'b1, m2reg: 1'b1, mo: '0, alu: 32'h0000_0A0C, rn: 5'd17});
    issue(1'b1, 1'b1, 1'b1, 32'h0000_0A0C, 32'h7777_0001, 5'd17, 2, 32'h0000_CAFE, n, e, t, bb);
    got = {wwreg, wm2reg, wmo, walu, wrn}; ex = exp_q.pop_front();
    checks++;
    if (n !== 2 || t || got !== ex) begin
      errors++; $display("FAIL both_mw: got %h stall=%0d exp %h stall=2", got, n, ex);
    end
    checks++;
    a = (acc_q.size() > 0) ? acc_q.pop_front() : '0;
    if (a !== {1'b1, 32'h0000_0A0C, 32'h7777_0001} || unstable !== 1'b0) begin
      errors++; $display("FAIL both_access: got we=%b addr=%h wdata=%h exp 1 a0c 77770001", a.we, a.addr, a.wdata);
    end
    drive_nop();
  endtask

  task automatic test_back_to_back();
    int n1, n2; logic e, t1, t2, bb; mw_bus_t got, ex; acc_t a0, a1;
    acc_q.delete(); unstable = 1'b0;
    exp_q.push_back('{wreg: 1'b1, m2reg: 1'b1, mo: 32'h0BAD_F00D, alu: 32'h300, rn: 5'd3});
    exp_q.push_back('{wreg: 1'b0, m2reg: 1'b0, mo: '0, alu: 32'h304, rn: 5'd4});
    issue(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd3, 1, 32'h0BAD_F00D, n1, e, t1, bb);
    got = {wwreg, wm2reg, wmo, walu, wrn}; ex = exp_q.pop_front();
    checks++;
    if (n1 !== 1 || t1 || got !== ex) begin
      errors++; $display("FAIL b2b_load: got %h stall=%0d exp %h stall=1", got, n1, ex);
    end
    issue(1'b0, 1'b0, 1'b1, 32'h304, 32'h0000_A5A5, 5'd4, 1, 32'h1234_5678, n2, e, t2, bb);
    got = {wwreg, wm2reg, wmo, walu, wrn}; ex = exp_q.pop_front();
    checks++;
    if (n2 !== 1 || t2 || got !== ex) begin
      errors++; $display("FAIL b2b_store: got %h stall=%0d exp %h stall=1", got, n2, ex);
    end
    checks++;
    if (acc_q.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d accesses exp 2", acc_q.size());
    end else begin
      a0 = acc_q.pop_front(); a1 = acc_q.pop_front();
      if (a0 !== {1'b0, 32'h300, 32'h0} || a1 !== {1'b1, 32'h304, 32'h0000_A5A5}) begin
        errors++; $display("FAIL b2b_order: got %h / %h exp load 300 then store 304", a0, a1);
      end
    end
    drive_nop();
  endtask

  task automatic test_idle_ack();
    int n; logic e, t, bb; mw_bus_t got, ex;
    acc_q.delete();
    idle_ack = 1'b1;
    exp_q.push_back('{wreg: 1'b1, m2reg: 1'b0, mo: '0, alu: 32'h77, rn: 5'd12});
    issue(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd12, 1, 32'hFFFF_0000, n, e, t, bb);
    got = {wwreg, wm2reg, wmo, walu, wrn}; ex = exp_q.pop_front();
    checks++;
    if (n !== 0 || got !== ex || dif.dmem_req !== 1'b0 || acc_q.size() != 0) begin
      errors++; $display("FAIL idle_ack: got %h stall=%0d req=%b exp %h 0 0", got, n, dif.dmem_req, ex);
    end
    idle_ack = 1'b0;
    drive_nop();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
`ifdef PIPE_MEM_TIMEOUT_EN
    int n; logic e, t, bb; mw_bus_t got, ex;
    acc_q.delete();
    exp_q.push_back('{wreg: 1'b0, m2reg: 1'b1, mo: '0, alu: 32'h400, rn: 5'd6});
    issue(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd6, 0, 32'h0, n, e, t, bb);
    got = {wwreg, wm2reg, wmo, walu, wrn}; ex = exp_q.pop_front();
    checks++;
    if (n !== 4 || t || e !== 1'b1) begin
      errors++; $display("FAIL timeout_stall: got stall=%0d mem_err_seen=%b exp 4 1", n, e);
    end
    checks++;
    if (got !== ex) begin
      errors++; $display("FAIL timeout_mw: got %h exp %h", got, ex);
    end
    checks++;
    if (dif.dmem_req !== 1'b0 || mem_err !== 1'b0 || acc_q.size() != 0) begin
      errors++; $display("FAIL timeout_after: got req=%b mem_err=%b exp 0 0", dif.dmem_req, mem_err);
    end
    drive_nop();
`else
    logic bad;
    bad = 1'b0;
    ack_k = 0;
    mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h400; mrn = 5'd6;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (stall !== 1'b1 || mem_err !== 1'b0) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad || dif.dmem_req !== 1'b1) begin
      errors++; $display("FAIL no_timeout_wait: got stall drop or mem_err, req=%b exp held 1", dif.dmem_req);
    end
    clrn = 1'b0;
    #2;
    drive_nop();
    clrn = 1'b1;
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic test_reset_wait();
    logic bad;
    ack_k = 0;
    mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h500; mb = 32'h0; mrn = 5'd10;
    @(posedge clk);
    #1;
    checks++;
    if (dif.dmem_req !== 1'b1 || dif.dmem_addr !== 32'h500) begin
      errors++; $display("FAIL rstwait_enter: got req=%b addr=%h exp 1 500", dif.dmem_req, dif.dmem_addr);
    end
    @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    drive_nop();
    #1;
    checks++;
    if ({dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata, wwreg, wm2reg, wmo, walu, wrn,
         mem_err, stall} !== 139'd0) begin
      errors++; $display("FAIL rstwait_clear: got req=%b mw=%b%b %h %h %h err=%b stall=%b exp all 0",
                         dif.dmem_req, wwreg, wm2reg, wmo, walu, wrn, mem_err, stall);
    end
    #2;
    clrn = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if ({wwreg, wm2reg, wmo, walu, wrn} !== 71'd0 || dif.dmem_req !== 1'b0 || stall !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL rstwait_after: got MEM/WB write or request after release exp none");
    end
  endtask

  initial begin
    drive_nop();
    test_reset();
    test_nonmemop();
    test_load();
    test_store();
    test_load_and_store();
    test_back_to_back();
    test_idle_ack();
    test_timeout();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_mem_stage.md
PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15, is the number of WAIT cycles without dmem_ack before abort (used only with PIPE_MEM_TIMEOUT_EN).
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 clrn  in  1  reset, asynchronous, active-low.
REQ-004 mwreg, mm2reg, mwmem  in  1 each  EX/MEM control (register write, load, store).
REQ-005 malu  in  32  effective address / ALU result; mb  in  32  store data; mrn  in  5  destination register.
REQ-006 dmem_ack  in  1  memory completion; dmem_rdata  in  32  load data, valid when dmem_ack=1.
REQ-007 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32  data-memory request, all registered.
REQ-008 stall  out  1  combinational; holds the EX/MEM register and all earlier pipeline stages.
REQ-009 wwreg, wm2reg  out  1 each; wmo  out  32; walu  out  32; wrn  out  5  MEM/WB register outputs.
REQ-010 mem_err  out  1  one-cycle timeout pulse; tied to 0 when PIPE_MEM_TIMEOUT_EN is undefined.

Function
REQ-011 FSM states: IDLE and WAIT. A memop is mm2reg|mwmem.
REQ-012 IDLE, no memop: stall=0; MEM/WB register loads wwreg=mwreg, wm2reg=mm2reg, walu=malu, wmo=0, wrn=mrn.
REQ-013 IDLE, memop: stall=1; MEM/WB register loads a bubble (wwreg=0, wm2reg=0); next state WAIT.
REQ-014 IDLE->WAIT: dmem_req<=1, dmem_we<=mwmem, dmem_addr<=malu, dmem_wdata<=mb.
REQ-015 dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable in WAIT until dmem_ack is sampled high.
REQ-016 WAIT, dmem_ack=0: stall=1; bubble into MEM/WB.
REQ-017 WAIT, dmem_ack=1: stall=0.
REQ-018 On that same edge, MEM/WB loads the instruction with wmo=dmem_rdata for loads and wmo=0 for stores.
REQ-019 On that same edge, dmem_req<=0 and the next state is IDLE.
REQ-020 Latency: a memop whose ack arrives on the k-th WAIT cycle holds stall for k cycles, and its MEM/WB result is visible k+1 cycles after it entered.
REQ-021 mm2reg=1 and mwmem=1 together is treated as a store: dmem_we=1, wm2reg forwarded unchanged, wmo=0.
REQ-022 dmem_ack while in IDLE is ignored.
REQ-023 A new memop arriving in the cycle after completion is accepted normally, with no idle gap required.

Reset
REQ-024 clrn=0 forces, asynchronously: state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
REQ-025 clrn=0 forces, asynchronously: wwreg=0, wm2reg=0, wmo=0, walu=0, wrn=0, mem_err=0, timeout counter=0.
REQ-026 Reset during WAIT abandons the access; no MEM/WB update follows.

Configuration
REQ-027 PIPE_MEM_TIMEOUT_EN defined: a counter increments each WAIT cycle and clears on entering WAIT.
REQ-028 On the WAIT cycle where the counter equals TIMEOUT_CYC-1 with dmem_ack=0: stall=0 and mem_err=1 for one cycle.
REQ-029 On that timeout edge: dmem_req<=0, next state IDLE, and MEM/WB loads with wwreg=0, wmo=0.
REQ-030 PIPE_MEM_TIMEOUT_EN undefined: WAIT lasts indefinitely until dmem_ack; no counter is built; mem_err=0.

Structure
REQ-031 Shared package pipe_pkg holds the FSM state typedef, the 32-bit data and 5-bit register-number width constants, and the TIMEOUT_CYC default.
REQ-032 The MEM/WB register is a sub-module pipemwreg (async clrn, load-or-bubble select); the FSM and request registers live in pipe_mem_stage.

Verification
REQ-033 Non-memop: mwreg=1, malu=0x0000_1234, mrn=5 -> next cycle wwreg=1, walu=0x1234, wrn=5, stall never 1.
REQ-034 Load: mm2reg=1, malu=0x100, ack after 3 WAIT cycles with rdata=0xDEAD_BEEF -> stall high 3 cycles, dmem_addr=0x100 stable, then wmo=0xDEADBEEF, wm2reg=1.
REQ-035 Store: mwmem=1, malu=0x200, mb=0x55 -> dmem_we=1, dmem_wdata=0x55; ack in first WAIT cycle -> stall 1 cycle, wwreg=0.
REQ-036 Back-to-back load then store, ack in first WAIT cycle each -> two requests, no lost or duplicated access.
REQ-037 Timeout (macro on, TIMEOUT_CYC=4), ack never asserted -> mem_err pulses once, dmem_req drops, stall releases after 4 WAIT cycles.
REQ-038 clrn pulsed low in WAIT -> dmem_req=0 immediately, all outputs 0, state IDLE, no MEM/WB write after release.
